// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, repeating it
// a programmable number of times with an optional idle gap between frames.
module seq_pattern_tx #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic [7:0]         repeat_in,
  input  logic [3:0]         gap_in,
  input  logic               abort,
  output logic               dout,
  output logic               dout_valid,
  output logic               busy,
  output logic               done,
  output logic [7:0]         frames_sent
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_t             state, state_n;
  logic [MAX_LEN-1:0] pat_q, pat_n;
  logic [LEN_W-1:0]   len_q, len_n;
  logic [3:0]         gap_q, gap_n;
  logic [7:0]         frames_left, frames_left_n;
  logic [3:0]         gap_cnt, gap_cnt_n;
  logic [LEN_W-1:0]   bit_idx, bit_idx_n;
  logic [7:0]         frames_sent_n;
  logic               dout_n, valid_n, busy_n, done_n;
  logic [LEN_W-1:0]   len_clamp;

  function automatic logic bit_at(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] idx);
    logic [MAX_LEN-1:0] s;
    s = p >> idx;
    return s[0];
  endfunction

  assign len_clamp = (len_in > MAX_LEN_L) ? MAX_LEN_L : len_in;

  // Outputs are computed one cycle ahead here and registered below, so the
  // value on dout always belongs to the state the FSM is currently in.
  always_comb begin
    state_n       = state;
    pat_n         = pat_q;
    len_n         = len_q;
    gap_n         = gap_q;
    frames_left_n = frames_left;
    gap_cnt_n     = gap_cnt;
    bit_idx_n     = bit_idx;
    frames_sent_n = frames_sent;
    dout_n        = 1'b0;
    valid_n       = 1'b0;
    busy_n        = 1'b0;
    done_n        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          pat_n         = pattern_in;
          len_n         = len_clamp;
          gap_n         = gap_in;
          frames_left_n = repeat_in;
          frames_sent_n = 8'd0;
          if (len_clamp == '0 || repeat_in == 8'd0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n   = SEND;
            bit_idx_n = len_clamp - 1'b1;
            dout_n    = bit_at(pattern_in, len_clamp - 1'b1);
            valid_n   = 1'b1;
            busy_n    = 1'b1;
          end
        end
      end
      SEND: begin
        if (abort) begin
          state_n = IDLE;
        end else if (bit_idx != '0) begin
          bit_idx_n = bit_idx - 1'b1;
          dout_n    = bit_at(pat_q, bit_idx - 1'b1);
          valid_n   = 1'b1;
          busy_n    = 1'b1;
        end else begin
          frames_sent_n = frames_sent + 8'd1;
          frames_left_n = frames_left - 8'd1;
          if (frames_left == 8'd1) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else if (gap_q != 4'd0) begin
            state_n   = GAP;
            gap_cnt_n = gap_q;
            busy_n    = 1'b1;
          end else begin
            bit_idx_n = len_q - 1'b1;
            dout_n    = bit_at(pat_q, len_q - 1'b1);
            valid_n   = 1'b1;
            busy_n    = 1'b1;
          end
        end
      end
      GAP: begin
        // gap_cnt holds the number of gap cycles left, including this one
        if (abort) begin
          state_n = IDLE;
        end else if (gap_cnt == 4'd1) begin
          state_n   = SEND;
          bit_idx_n = len_q - 1'b1;
          dout_n    = bit_at(pat_q, len_q - 1'b1);
          valid_n   = 1'b1;
          busy_n    = 1'b1;
        end else begin
          gap_cnt_n = gap_cnt - 4'd1;
          busy_n    = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      gap_q       <= '0;
      frames_left <= '0;
      gap_cnt     <= '0;
      bit_idx     <= '0;
      frames_sent <= '0;
      dout        <= 1'b0;
      dout_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      pat_q       <= pat_n;
      len_q       <= len_n;
      gap_q       <= gap_n;
      frames_left <= frames_left_n;
      gap_cnt     <= gap_cnt_n;
      bit_idx     <= bit_idx_n;
      frames_sent <= frames_sent_n;
      dout        <= dout_n;
      dout_valid  <= valid_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: a per-cycle expected-output queue built from the
// job description, plus literal checks on the captured bit streams.
module tb_seq_pattern_tx;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int W       = 12;  // {busy, dout_valid, dout, done, frames_sent[7:0]}

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [MAX_LEN-1:0] pattern_in = '0;
  logic [LEN_W-1:0]   len_in = '0;
  logic [7:0]         repeat_in = '0;
  logic [3:0]         gap_in = '0;
  logic               dout, dout_valid, busy, done;
  logic [7:0]         frames_sent;

  seq_pattern_tx #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern_in(pattern_in), .len_in(len_in),
    .repeat_in(repeat_in), .gap_in(gap_in), .abort(abort), .dout(dout),
    .dout_valid(dout_valid), .busy(busy), .done(done), .frames_sent(frames_sent)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic [7:0]   exp_frames = 8'd0;
  int           n_tests = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           job_cyc = 0;
  int           done_rel = -1;
  int           nbits = 0;
  logic [31:0]  cap = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  // Model: the whole job expands into one expected output word per cycle.
  function automatic void push_job(logic [7:0] p, logic [3:0] l, logic [7:0] r, logic [3:0] g);
    int len;
    len = (l > MAX_LEN) ? MAX_LEN : int'(l);
    if (len == 0 || r == 0) begin
      exp_q.push_back({4'b0001, 8'd0});
    end else begin
      for (int f = 0; f < int'(r); f++) begin
        for (int b = len - 1; b >= 0; b--)
          exp_q.push_back({2'b11, p[b], 1'b0, 8'(f)});
        if (f < int'(r) - 1)
          for (int k = 0; k < int'(g); k++)
            exp_q.push_back({4'b1000, 8'(f + 1)});
      end
      exp_q.push_back({4'b0001, r});
    end
  endfunction

  // compare process: every cycle after the first reset edge
  initial begin
    logic [W-1:0] e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc++;
      if (dout_valid === 1'b1) begin
        cap = {cap[30:0], dout};
        nbits++;
      end
      if (done === 1'b1) done_rel = cyc - job_cyc;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        exp_frames = e[7:0];
      end else begin
        e = {4'b0000, exp_frames};
      end
      check($sformatf("busy@%0d", cyc), busy, e[11]);
      check($sformatf("dout_valid@%0d", cyc), dout_valid, e[10]);
      check($sformatf("dout@%0d", cyc), dout, e[9]);
      check($sformatf("done@%0d", cyc), done, e[8]);
      check($sformatf("frames_sent@%0d", cyc), frames_sent, e[7:0]);
    end
  end

  // driver tasks: all entered and left just after a rising edge
  task automatic model_start(input logic [7:0] p, input logic [3:0] l,
                             input logic [7:0] r, input logic [3:0] g);
    push_job(p, l, r, g);
    job_cyc = cyc;
    cap = '0;
    nbits = 0;
    done_rel = -1;
  endtask

  task automatic launch(input logic [7:0] p, input logic [3:0] l,
                        input logic [7:0] r, input logic [3:0] g);
    pattern_in = p;
    len_in = l;
    repeat_in = r;
    gap_in = g;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pattern_in = 8'($urandom_range(0, 255));
    len_in = 4'($urandom_range(0, 15));
    repeat_in = 8'($urandom_range(0, 255));
    gap_in = 4'($urandom_range(0, 15));
    model_start(p, l, r, g);
  endtask

  task automatic wait_drain(input string name);
    int k;
    for (k = 0; k < 300 && exp_q.size() != 0; k++) begin
      @(negedge clk); #1;
    end
    check({name, " drain"}, 32'(exp_q.size() == 0), 32'd1);
    @(posedge clk); #1;
  endtask

  // directed vectors
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset busy", busy, 1'b0);
    check("reset frames", frames_sent, 8'd0);

    // single frame
    launch(8'h15, 4'd5, 8'd1, 4'd0);
    wait_drain("single");
    check("single bits", cap, 32'h15);
    check("single nbits", nbits, 5);
    check("single done cycle", done_rel, 6);
    check("single frames", frames_sent, 8'd1);

    // back-to-back repeat
    launch(8'h15, 4'd5, 8'd3, 4'd0);
    wait_drain("repeat");
    check("repeat bits", cap, 32'b101011010110101);
    check("repeat nbits", nbits, 15);
    check("repeat done cycle", done_rel, 16);
    check("repeat frames", frames_sent, 8'd3);

    // gap between frames
    launch(8'h15, 4'd5, 8'd2, 4'd2);
    wait_drain("gap");
    check("gap bits", cap, 32'b1010110101);
    check("gap done cycle", done_rel, 13);

    // degenerate inputs
    launch(8'h15, 4'd0, 8'd4, 4'd0);
    wait_drain("len0");
    check("len0 nbits", nbits, 0);
    check("len0 done cycle", done_rel, 1);
    check("len0 frames", frames_sent, 8'd0);
    launch(8'h15, 4'd5, 8'd0, 4'd1);
    wait_drain("rep0");
    check("rep0 done cycle", done_rel, 1);
    launch(8'hA5, 4'd12, 8'd1, 4'd0);
    wait_drain("clamp");
    check("clamp bits", cap, 32'hA5);
    check("clamp nbits", nbits, 8);

    // abort during the 3rd bit of the 2nd frame (cycle 8)
    launch(8'h15, 4'd5, 8'd3, 4'd0);
    repeat (7) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    repeat (3) begin @(posedge clk); #1; end
    check("abort busy", busy, 1'b0);
    check("abort frames", frames_sent, 8'd1);
    check("abort no done", done_rel, -1);
    check("abort nbits", nbits, 8);

    // start and abort together in IDLE: start wins
    abort = 1'b1;
    launch(8'h15, 4'd5, 8'd1, 4'd0);
    abort = 1'b0;
    wait_drain("start_abort");
    check("start_abort nbits", nbits, 5);

    // start while busy is ignored
    launch(8'h15, 4'd5, 8'd2, 4'd1);
    repeat (3) begin @(posedge clk); #1; end
    pattern_in = 8'hFF;
    len_in = 4'd8;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_drain("busy_start");
    check("busy_start bits", cap, 32'b1010110101);
    check("busy_start done cycle", done_rel, 12);

    // start in DONE is ignored; accepted on the following IDLE edge
    launch(8'h01, 4'd1, 8'd1, 4'd0);
    @(posedge clk); #1;
    pattern_in = 8'h03;
    len_in = 4'd2;
    repeat_in = 8'd1;
    gap_in = 4'd0;
    start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    model_start(8'h03, 4'd2, 8'd1, 4'd0);
    wait_drain("done_start");
    check("done_start bits", cap, 32'h3);
    check("done_start done cycle", done_rel, 3);

    // reset mid-frame
    launch(8'h15, 4'd5, 8'd2, 4'd0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    exp_frames = 8'd0;
    check("rst busy", busy, 1'b0);
    check("rst valid", dout_valid, 1'b0);
    check("rst frames", frames_sent, 8'd0);
    repeat (3) begin @(posedge clk); #1; end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
